// File: rtl/cpu8_service_pkg.sv
// rtl/cpu8_service_pkg.sv - shared states, opcodes and command classes for the service loader
package cpu8_service_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_ADDR,
        S_GET_LEN,
        S_WRITE,
        S_RD_WAIT,
        S_RD_SEND,
        S_RUN_RST
    } state_t;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_LOADP,
        CMD_LOADD,
        CMD_READD,
        CMD_RUN,
        CMD_HALT
    } cmd_t;

    localparam logic [7:0] OP_LOADP = 8'h01;
    localparam logic [7:0] OP_LOADD = 8'h02;
    localparam logic [7:0] OP_READD = 8'h03;
    localparam logic [7:0] OP_RUN   = 8'h04;
    localparam logic [7:0] OP_HALT  = 8'h05;

endpackage

// File: rtl/cpu8_service_cmd_decode.sv
// rtl/cpu8_service_cmd_decode.sv - combinational opcode to command-class decoder
module cpu8_service_cmd_decode
    import cpu8_service_pkg::*;
(
    input  logic [7:0] opcode,
    output cmd_t       cmd
);

    always_comb begin
        cmd = CMD_NONE;
        case (opcode)
            OP_LOADP: cmd = CMD_LOADP;
            OP_LOADD: cmd = CMD_LOADD;
            OP_READD: cmd = CMD_READD;
            OP_RUN:   cmd = CMD_RUN;
            OP_HALT:  cmd = CMD_HALT;
            default:  cmd = CMD_NONE;
        endcase
    end

endmodule

// File: rtl/cpu8_service_loader.sv
// rtl/cpu8_service_loader.sv - byte-command loader that halts, loads, reads back and restarts an 8-bit CPU
module cpu8_service_loader
    import cpu8_service_pkg::*;
#(
    parameter int RST_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    input  logic       rsp_ready,
    output logic       service_mode,
    output logic       cpu_rst,
    output logic [7:0] prog_addr,
    output logic [7:0] prog_wdata,
    output logic       prog_we,
    output logic [7:0] data_addr,
    output logic [7:0] data_wdata,
    output logic       data_we,
    input  logic [7:0] data_rdata,
    output logic       busy
);

    state_t     state, state_next;
    cmd_t       op_cls;
    cmd_t       cur_cmd;
    logic [7:0] ptr;
    logic [8:0] cnt;
    logic [3:0] rst_cnt;
    logic [7:0] rsp_q;
    logic       svc_q;
    logic       hold1, hold2;
    logic       cmd_fire;
    logic       is_mem_cmd;

    cpu8_service_cmd_decode u_decode (
        .opcode (cmd_data),
        .cmd    (op_cls)
    );

    assign cmd_fire   = cmd_valid & cmd_ready;
    assign is_mem_cmd = (op_cls == CMD_LOADP) || (op_cls == CMD_LOADD) || (op_cls == CMD_READD);

    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        prog_we    = 1'b0;
        data_we    = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (is_mem_cmd)
                        state_next = S_GET_ADDR;
                    else if (op_cls == CMD_RUN)
                        state_next = S_RUN_RST;
                end
            end
            S_GET_ADDR: begin
                cmd_ready = 1'b1;
                if (cmd_valid)
                    state_next = S_GET_LEN;
            end
            S_GET_LEN: begin
                cmd_ready = 1'b1;
                if (cmd_valid)
                    state_next = (cur_cmd == CMD_READD) ? S_RD_WAIT : S_WRITE;
            end
            S_WRITE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    prog_we = (cur_cmd == CMD_LOADP);
                    data_we = (cur_cmd == CMD_LOADD);
                    if (cnt == 9'd1)
                        state_next = S_IDLE;
                end
            end
            S_RD_WAIT: state_next = S_RD_SEND;
            S_RD_SEND: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_next = (cnt == 9'd1) ? S_IDLE : S_RD_WAIT;
            end
            S_RUN_RST: begin
                if (rst_cnt == 4'd0)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // hold1/hold2 keep cpu_rst asserted through the first clock after reset release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cur_cmd <= CMD_NONE;
            ptr     <= 8'd0;
            cnt     <= 9'd0;
            rst_cnt <= 4'd0;
            rsp_q   <= 8'd0;
            svc_q   <= 1'b1;
            hold1   <= 1'b1;
            hold2   <= 1'b1;
        end else begin
            state <= state_next;
            hold1 <= 1'b0;
            hold2 <= hold1;
            case (state)
                S_IDLE: begin
                    if (cmd_fire) begin
                        if (is_mem_cmd) begin
                            cur_cmd <= op_cls;
                            svc_q   <= 1'b1;
                        end else if (op_cls == CMD_HALT) begin
                            svc_q <= 1'b1;
                        end else if (op_cls == CMD_RUN) begin
                            svc_q   <= 1'b0;
                            rst_cnt <= 4'(RST_CYCLES - 1);
                        end
                    end
                end
                S_GET_ADDR: if (cmd_fire) ptr <= cmd_data;
                S_GET_LEN:  if (cmd_fire) cnt <= (cmd_data == 8'd0) ? 9'd256 : {1'b0, cmd_data};
                S_WRITE: begin
                    if (cmd_fire) begin
                        ptr <= ptr + 8'd1;
                        cnt <= cnt - 9'd1;
                    end
                end
                S_RD_WAIT: rsp_q <= data_rdata;
                S_RD_SEND: begin
                    if (rsp_ready) begin
                        ptr <= ptr + 8'd1;
                        cnt <= cnt - 9'd1;
                    end
                end
                S_RUN_RST: if (rst_cnt != 4'd0) rst_cnt <= rst_cnt - 4'd1;
                default: ;
            endcase
        end
    end

    assign service_mode = svc_q;
    assign cpu_rst      = hold2 | (state == S_RUN_RST);
    assign busy         = (state != S_IDLE);
    assign rsp_data     = rsp_q;
    assign prog_addr    = ptr;
    assign data_addr    = ptr;
    assign prog_wdata   = cmd_data;
    assign data_wdata   = cmd_data;

endmodule

// File: tb/tb_cpu8_service_loader.sv
// tb/tb_cpu8_service_loader.sv - directed and randomized checks of the service loader against a memory model
module tb_cpu8_service_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic       cmd_ready;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_ready;
    logic       service_mode;
    logic       cpu_rst;
    logic [7:0] prog_addr, prog_wdata, data_addr, data_wdata, data_rdata;
    logic       prog_we, data_we;
    logic       busy;

    always #5 clk = ~clk;

    cpu8_service_loader #(.RST_CYCLES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_data     (cmd_data),
        .cmd_ready    (cmd_ready),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_ready    (rsp_ready),
        .service_mode (service_mode),
        .cpu_rst      (cpu_rst),
        .prog_addr    (prog_addr),
        .prog_wdata   (prog_wdata),
        .prog_we      (prog_we),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_we      (data_we),
        .data_rdata   (data_rdata),
        .busy         (busy)
    );

    logic [7:0]  prog_mem [256];
    logic [7:0]  data_mem [256];
    logic [7:0]  ref_prog [256];
    logic [7:0]  ref_data [256];
    logic [15:0] exp_p[$];
    logic [15:0] exp_d[$];
    logic [7:0]  payload[$];
    logic        ref_svc;
    int          n_pw, n_dw;
    logic [7:0]  last_da;
    int          checks, errors;

    assign data_rdata = data_mem[data_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (prog_we) begin
                n_pw++;
                check("prog_we_svc", service_mode, 1);
                if (exp_p.size() == 0) check("prog_we_unexpected", {prog_addr, prog_wdata}, 0);
                else check("prog_write", {prog_addr, prog_wdata}, exp_p.pop_front());
                prog_mem[prog_addr] = prog_wdata;
            end
            if (data_we) begin
                n_dw++;
                last_da = data_addr;
                check("data_we_svc", service_mode, 1);
                if (exp_d.size() == 0) check("data_we_unexpected", {data_addr, data_wdata}, 0);
                else check("data_write", {data_addr, data_wdata}, exp_d.pop_front());
                data_mem[data_addr] = data_wdata;
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int   n;
        logic hs;
        n = 0;
        cmd_data  = b;
        cmd_valid = 1'b1;
        do begin
            @(negedge clk);
            hs = cmd_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!hs && n < 50);
        if (!hs) check("send_timeout", 0, 1);
        cmd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Load len bytes from payload (or random); gap inserts one idle cycle after every byte
    task automatic load(input logic [7:0] op, input logic [7:0] addr, input int len, input bit gap);
        logic [7:0] a, b;
        send(op);
        check("load_svc_raised", service_mode, 1);
        ref_svc = 1'b1;
        send(addr);
        send(8'(len));
        for (int i = 0; i < len; i++) begin
            a = 8'((int'(addr) + i) % 256);
            b = (payload.size() > 0) ? payload.pop_front() : 8'($urandom);
            if (op == 8'h01) begin
                exp_p.push_back({a, b});
                ref_prog[a] = b;
            end else begin
                exp_d.push_back({a, b});
                ref_data[a] = b;
            end
            send(b);
            if (gap) idle(1);
        end
        check("load_done_idle", busy, 0);
        check("load_queue_empty", exp_p.size() + exp_d.size(), 0);
    endtask

    task automatic read(input logic [7:0] addr, input int len, input int stall);
        logic [7:0] v, e;
        int         n;
        send(8'h03);
        ref_svc = 1'b1;
        send(addr);
        send(8'(len));
        for (int i = 0; i < len; i++) begin
            e = ref_data[8'((int'(addr) + i) % 256)];
            n = 0;
            @(negedge clk);
            while (!rsp_valid && n < 20) begin
                n++;
                @(negedge clk);
            end
            check("rsp_valid_seen", rsp_valid, 1);
            v = rsp_data;
            check("rsp_data", v, e);
            for (int k = 0; k < stall; k++) begin
                @(negedge clk);
                check("rsp_hold", {rsp_valid, rsp_data}, {1'b1, e});
            end
            rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            rsp_ready = 1'b0;
        end
        check("read_done_idle", busy, 0);
    endtask

    task automatic run_cmd();
        int n;
        send(8'h04);
        ref_svc = 1'b0;
        n = 0;
        @(negedge clk);
        while (cpu_rst && n < 20) begin
            if (service_mode !== 1'b0) check("run_svc_low", service_mode, 0);
            n++;
            @(negedge clk);
        end
        check("run_rst_cycles", n, 2);
        check("run_svc_after", service_mode, 0);
        check("run_busy_after", busy, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         op, mism, pw0, dw0;
        logic [7:0] j;
        checks = 0; errors = 0; n_pw = 0; n_dw = 0; last_da = 0;
        for (int i = 0; i < 256; i++) begin
            prog_mem[i] = 8'h00;
            ref_prog[i] = 8'h00;
            data_mem[i] = 8'($urandom);
            ref_data[i] = data_mem[i];
        end
        ref_svc   = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
        rsp_ready = 1'b0;
        rst       = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_svc", service_mode, 1);
        check("rst_cpu_rst", cpu_rst, 1);
        check("rst_strobes", {rsp_valid, prog_we, data_we}, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_ptr", prog_addr, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        check("cpu_rst_first_cycle", cpu_rst, 1);
        idle(3);
        check("cpu_rst_released", cpu_rst, 0);

        // Wrap across 0xFF
        payload = '{8'hAA, 8'hBB, 8'hCC};
        load(8'h01, 8'hFE, 3, 1'b0);
        check("wrap_fe", prog_mem[8'hFE], 8'hAA);
        check("wrap_ff", prog_mem[8'hFF], 8'hBB);
        check("wrap_00", prog_mem[8'h00], 8'hCC);

        // len=0 means 256, with sender stalling every other cycle
        dw0 = n_dw;
        load(8'h02, 8'h10, 256, 1'b1);
        check("stall_count", n_dw - dw0, 256);
        check("stall_last_addr", last_da, 8'h0F);

        // Readback with host back-pressure
        data_mem[8'h20] = 8'h11; ref_data[8'h20] = 8'h11;
        data_mem[8'h21] = 8'h22; ref_data[8'h21] = 8'h22;
        read(8'h20, 2, 5);

        // Run then reload
        run_cmd();
        load(8'h01, 8'h30, 4, 1'b0);

        // Junk byte
        pw0 = n_pw; dw0 = n_dw;
        send(8'h7F);
        idle(1);
        check("junk_idle", busy, 0);
        check("junk_no_strobes", (n_pw - pw0) + (n_dw - dw0), 0);

        // Reset mid-WRITE
        send(8'h01);
        send(8'h40);
        send(8'h05);
        for (int i = 0; i < 2; i++) begin
            j = 8'($urandom);
            exp_p.push_back({8'(8'h40 + i), j});
            ref_prog[8'(8'h40 + i)] = j;
            send(j);
        end
        rst = 1'b1;
        cmd_data = 8'h99;
        cmd_valid = 1'b1;
        #1;
        check("midrst_prog_we", prog_we, 0);
        check("midrst_busy", busy, 0);
        check("midrst_svc", service_mode, 1);
        check("midrst_cpu_rst", cpu_rst, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        rst = 1'b0;
        ref_svc = 1'b1;
        @(negedge clk);
        check("postrst_svc", service_mode, 1);
        check("postrst_prog_we", prog_we, 0);
        check("postrst_busy", busy, 0);
        @(posedge clk);
        #1;
        send(8'h05);
        check("halt_after_rst_idle", busy, 0);
        check("halt_after_rst_svc", service_mode, 1);

        // Randomized command mix against the memory model
        for (int t = 0; t < 30; t++) begin
            op = $urandom_range(0, 5);
            case (op)
                0: load(8'h01, 8'($urandom), $urandom_range(1, 8), 1'($urandom));
                1: load(8'h02, 8'($urandom), $urandom_range(1, 8), 1'($urandom));
                2: read(8'($urandom), $urandom_range(1, 6), $urandom_range(0, 3));
                3: begin
                    send(8'h05);
                    ref_svc = 1'b1;
                end
                4: run_cmd();
                default: begin
                    j = 8'($urandom_range(6, 255));
                    send(j);
                end
            endcase
            check("rand_svc", service_mode, ref_svc);
            check("rand_idle", busy, 0);
        end

        mism = 0;
        for (int i = 0; i < 256; i++) begin
            if (prog_mem[i] !== ref_prog[i]) mism++;
            if (data_mem[i] !== ref_data[i]) mism++;
        end
        check("final_memories", mism, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1, "timeout");
    end

endmodule
